// File: rtl/mem_access.sv
// MEM pipeline stage: moves load/store data over a byte-wide bus, one byte per
// granted cycle, and holds the pipeline until the access completes.
//
// state | meaning
// IDLE  | no access in flight; byte 0 issues here as soon as a mem op appears
// XFER  | issuing bytes 1..N-1, one per granted cycle
// DRAIN | loads only: last read byte returns this cycle
// DONE  | result presented to MEM_WB, stall released
module mem_access #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic [5:0]        instIdx_in,
    input  logic [ADDR_W-1:0] memAddr_in,
    input  logic [DATA_W-1:0] valStore_in,
    input  logic              rdE_in,
    input  logic [4:0]        rdIdx_in,
    input  logic [DATA_W-1:0] rdData_in,
    input  logic              memGrant_in,
    input  logic [7:0]        memData_in,
    output logic              memReq_out,
    output logic [ADDR_W-1:0] memAddr_out,
    output logic [7:0]        memData_out,
    output logic              memWr_out,
    output logic              stallReq_out,
    output logic              rdE_out,
    output logic [4:0]        rdIdx_out,
    output logic [DATA_W-1:0] rdData_out
);

    localparam logic [5:0] INST_LB  = 6'd10;
    localparam logic [5:0] INST_LH  = 6'd11;
    localparam logic [5:0] INST_LW  = 6'd12;
    localparam logic [5:0] INST_LBU = 6'd13;
    localparam logic [5:0] INST_LHU = 6'd14;
    localparam logic [5:0] INST_SB  = 6'd15;
    localparam logic [5:0] INST_SH  = 6'd16;
    localparam logic [5:0] INST_SW  = 6'd17;

    localparam logic [4:0] REG_NOP = 5'd0;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_XFER  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]        state;
    logic [2:0]        cnt;
    logic [DATA_W-1:0] buffer;
    logic              pend_rd;
    logic [1:0]        pend_idx;

    logic              is_load;
    logic              is_store;
    logic              ext_sign;
    logic [2:0]        n_bytes;
    logic              mem_op;
    logic              issuing;
    logic              last_byte;
    logic [DATA_W-1:0] load_val;

    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        ext_sign = 1'b0;
        n_bytes  = 3'd0;
        case (instIdx_in)
            INST_LB:  begin is_load  = 1'b1; ext_sign = 1'b1; n_bytes = 3'd1; end
            INST_LH:  begin is_load  = 1'b1; ext_sign = 1'b1; n_bytes = 3'd2; end
            INST_LW:  begin is_load  = 1'b1; n_bytes = 3'd4; end
            INST_LBU: begin is_load  = 1'b1; n_bytes = 3'd1; end
            INST_LHU: begin is_load  = 1'b1; n_bytes = 3'd2; end
            INST_SB:  begin is_store = 1'b1; n_bytes = 3'd1; end
            INST_SH:  begin is_store = 1'b1; n_bytes = 3'd2; end
            INST_SW:  begin is_store = 1'b1; n_bytes = 3'd4; end
            default:  ;
        endcase
    end

    assign mem_op    = is_load | is_store;
    // IDLE issues byte 0 directly so a continuously granted load costs only N+2 cycles.
    assign issuing   = mem_op && ((state == S_IDLE) || (state == S_XFER));
    assign last_byte = (cnt == n_bytes - 3'd1);

    always_comb begin
        case (n_bytes)
            3'd1:    load_val = {{(DATA_W-8){ext_sign & buffer[7]}}, buffer[7:0]};
            3'd2:    load_val = {{(DATA_W-16){ext_sign & buffer[15]}}, buffer[15:0]};
            default: load_val = buffer;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state    <= S_IDLE;
            cnt      <= 3'd0;
            buffer   <= '0;
            pend_rd  <= 1'b0;
            pend_idx <= 2'd0;
        end else begin
            // The byte requested last cycle arrives now, whatever the grant is doing.
            if (pend_rd) begin
                buffer[8*pend_idx +: 8] <= memData_in;
            end
            pend_rd <= 1'b0;

            case (state)
                S_IDLE, S_XFER: begin
                    if (issuing && memGrant_in) begin
                        cnt      <= cnt + 3'd1;
                        pend_rd  <= is_load;
                        pend_idx <= cnt[1:0];
                        if (last_byte) begin
                            state <= is_store ? S_DONE : S_DRAIN;
                        end else begin
                            state <= S_XFER;
                        end
                    end
                end
                S_DRAIN: state <= S_DONE;
                S_DONE: begin
                    state <= S_IDLE;
                    cnt   <= 3'd0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Outputs are held at their reset values while rst_in is high so an aborted
    // store cannot put another write on the bus.
    always_comb begin
        memReq_out   = 1'b0;
        memAddr_out  = '0;
        memData_out  = 8'd0;
        memWr_out    = 1'b0;
        stallReq_out = 1'b0;
        rdE_out      = 1'b0;
        rdIdx_out    = REG_NOP;
        rdData_out   = '0;
        if (!rst_in) begin
            if (!mem_op) begin
                rdE_out    = rdE_in;
                rdIdx_out  = rdIdx_in;
                rdData_out = rdData_in;
            end else begin
                rdIdx_out    = rdIdx_in;
                stallReq_out = (state != S_DONE);
                if (issuing) begin
                    memReq_out  = 1'b1;
                    memAddr_out = memAddr_in + ADDR_W'(cnt);
                    memWr_out   = is_store;
                    memData_out = valStore_in[8*cnt[1:0] +: 8];
                end
                if ((state == S_DONE) && is_load) begin
                    rdE_out    = rdE_in;
                    rdData_out = load_val;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: directed vector table, randomized transactions against a
// byte-level reference model, plus pass-through and mid-access reset sequences.
module tb_mem_access;

    localparam logic [5:0] I_NOP = 6'd0;
    localparam logic [5:0] I_ADD = 6'd1;
    localparam logic [5:0] I_LB  = 6'd10;
    localparam logic [5:0] I_LH  = 6'd11;
    localparam logic [5:0] I_LW  = 6'd12;
    localparam logic [5:0] I_LBU = 6'd13;
    localparam logic [5:0] I_LHU = 6'd14;
    localparam logic [5:0] I_SB  = 6'd15;
    localparam logic [5:0] I_SH  = 6'd16;
    localparam logic [5:0] I_SW  = 6'd17;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] addr;
        logic [31:0] sval;
        logic [31:0] rbytes;
        logic [15:0] gmask;
        logic        rde;
        logic [4:0]  ridx;
        logic [31:0] exp_res;
        int          exp_stall;
    } vec_t;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [5:0]  instIdx_in;
    logic [31:0] memAddr_in;
    logic [31:0] valStore_in;
    logic        rdE_in;
    logic [4:0]  rdIdx_in;
    logic [31:0] rdData_in;
    logic        memGrant_in;
    logic [7:0]  memData_in;
    logic        memReq_out;
    logic [31:0] memAddr_out;
    logic [7:0]  memData_out;
    logic        memWr_out;
    logic        stallReq_out;
    logic        rdE_out;
    logic [4:0]  rdIdx_out;
    logic [31:0] rdData_out;

    int errors = 0;
    int checks = 0;

    vec_t vecs[10];

    mem_access #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .instIdx_in  (instIdx_in),
        .memAddr_in  (memAddr_in),
        .valStore_in (valStore_in),
        .rdE_in      (rdE_in),
        .rdIdx_in    (rdIdx_in),
        .rdData_in   (rdData_in),
        .memGrant_in (memGrant_in),
        .memData_in  (memData_in),
        .memReq_out  (memReq_out),
        .memAddr_out (memAddr_out),
        .memData_out (memData_out),
        .memWr_out   (memWr_out),
        .stallReq_out(stallReq_out),
        .rdE_out     (rdE_out),
        .rdIdx_out   (rdIdx_out),
        .rdData_out  (rdData_out)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int nbytes(input logic [5:0] op);
        case (op)
            I_LB, I_LBU, I_SB: return 1;
            I_LH, I_LHU, I_SH: return 2;
            I_LW, I_SW:        return 4;
            default:           return 0;
        endcase
    endfunction

    function automatic bit is_st(input logic [5:0] op);
        return (op == I_SB) || (op == I_SH) || (op == I_SW);
    endfunction

    function automatic bit grant_at(input logic [15:0] gm, input int c);
        if (c >= 16) return 1'b1;
        return !gm[c[3:0]];
    endfunction

    // Little-endian assembly of the first N bytes, then two's-complement reinterpretation for LB/LH.
    function automatic logic [31:0] model_load(input logic [5:0] op, input logic [31:0] rb);
        int     n    = nbytes(op);
        longint span = longint'(1) << (8 * n);
        longint v    = longint'(rb) & (span - 1);
        if (((op == I_LB) || (op == I_LH)) && (v >= span / 2)) v = v - span;
        return v[31:0];
    endfunction

    // Issue ends at the cycle holding the N-th grant; loads add one drain cycle.
    function automatic int model_stall(input logic [5:0] op, input logic [15:0] gm);
        int granted = 0;
        for (int c = 0; c < 64; c++) begin
            if (grant_at(gm, c)) granted++;
            if (granted == nbytes(op)) return c + 1 + (is_st(op) ? 0 : 1);
        end
        return -1;
    endfunction

    task automatic run_txn(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] sval,
                           input logic [31:0] rbytes, input logic [15:0] gmask, input logic rde,
                           input logic [4:0] ridx, input logic [31:0] exp_res, input int exp_stall);
        int         n      = nbytes(op);
        int         k      = 0;
        int         stalls = 0;
        bit         done   = 1'b0;
        bit         pend   = 1'b0;
        logic [7:0] pend_byte = 8'd0;
        instIdx_in  = op;
        memAddr_in  = addr;
        valStore_in = sval;
        rdE_in      = rde;
        rdIdx_in    = ridx;
        rdData_in   = $urandom;
        for (int c = 0; c < 40 && !done; c++) begin
            memGrant_in = grant_at(gmask, c);
            memData_in  = pend ? pend_byte : 8'($urandom);
            pend = 1'b0;
            @(negedge clk_in);
            if (stallReq_out) begin
                stalls++;
                chk("rdE_while_stalled", 32'(rdE_out), 32'd0);
                chk("req_during_issue", 32'(memReq_out), 32'(k < n));
                if (memReq_out && memGrant_in && (k < n)) begin
                    chk("bus_addr", memAddr_out, addr + 32'(k));
                    chk("bus_wr", 32'(memWr_out), 32'(is_st(op)));
                    if (is_st(op)) begin
                        chk("bus_wdata", 32'(memData_out), 32'(sval[8*k +: 8]));
                    end else begin
                        pend      = 1'b1;
                        pend_byte = rbytes[8*k +: 8];
                    end
                    k++;
                end
            end else begin
                done = 1'b1;
                chk("stall_cycles", 32'(stalls), 32'(exp_stall));
                chk("bytes_issued", 32'(k), 32'(n));
                chk("done_req", 32'(memReq_out), 32'd0);
                if (is_st(op)) begin
                    chk("store_rdE", 32'(rdE_out), 32'd0);
                end else begin
                    chk("load_rdE", 32'(rdE_out), 32'(rde));
                    chk("load_rdIdx", 32'(rdIdx_out), 32'(ridx));
                    chk("load_data", rdData_out, exp_res);
                end
            end
            @(posedge clk_in);
            #1;
        end
        if (!done) begin
            errors++;
            checks++;
            $display("FAIL txn_timeout: op %0d got no DONE within 40 cycles, required DONE", op);
        end
        instIdx_in  = I_NOP;
        memGrant_in = 1'b0;
    endtask

    task automatic check_passthru(input logic [31:0] d, input logic rde, input logic [4:0] ridx);
        instIdx_in  = I_ADD;
        rdData_in   = d;
        rdE_in      = rde;
        rdIdx_in    = ridx;
        memAddr_in  = $urandom;
        memGrant_in = 1'($urandom);
        @(negedge clk_in);
        chk("pass_rdData", rdData_out, d);
        chk("pass_rdE", 32'(rdE_out), 32'(rde));
        chk("pass_rdIdx", 32'(rdIdx_out), 32'(ridx));
        chk("pass_stall", 32'(stallReq_out), 32'd0);
        chk("pass_req", 32'(memReq_out), 32'd0);
        @(posedge clk_in);
        #1;
        instIdx_in = I_NOP;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req"},    32'(memReq_out),   32'd0);
        chk({tag, "_wr"},     32'(memWr_out),    32'd0);
        chk({tag, "_stall"},  32'(stallReq_out), 32'd0);
        chk({tag, "_rdE"},    32'(rdE_out),      32'd0);
        chk({tag, "_addr"},   memAddr_out,       32'd0);
        chk({tag, "_wdata"},  32'(memData_out),  32'd0);
        chk({tag, "_rdData"}, rdData_out,        32'd0);
        chk({tag, "_rdIdx"},  32'(rdIdx_out),    32'd0);
    endtask

    initial begin
        vecs[0] = '{I_LW,  32'h0000_1000, 32'h0,         32'h1234_5678, 16'h0000, 1'b1, 5'd3,  32'h1234_5678, 5};
        vecs[1] = '{I_LB,  32'h0000_0020, 32'h0,         32'hDEAD_BE80, 16'h0000, 1'b1, 5'd4,  32'hFFFF_FF80, 2};
        vecs[2] = '{I_LBU, 32'h0000_0020, 32'h0,         32'h0000_0080, 16'h0000, 1'b1, 5'd5,  32'h0000_0080, 2};
        vecs[3] = '{I_LHU, 32'h0000_0040, 32'h0,         32'h0000_FFFF, 16'h0000, 1'b1, 5'd6,  32'h0000_FFFF, 3};
        vecs[4] = '{I_SH,  32'h0000_2001, 32'hABCD_1234, 32'h0,         16'h0000, 1'b1, 5'd7,  32'h0,         2};
        vecs[5] = '{I_LW,  32'h0000_3000, 32'h0,         32'h4433_2211, 16'h001C, 1'b1, 5'd8,  32'h4433_2211, 8};
        vecs[6] = '{I_SW,  32'hFFFF_FFFE, 32'hCAFE_F00D, 32'h0,         16'h0000, 1'b0, 5'd9,  32'h0,         4};
        vecs[7] = '{I_LH,  32'h0000_0003, 32'h0,         32'h0000_80FE, 16'h0000, 1'b1, 5'd10, 32'hFFFF_80FE, 3};
        vecs[8] = '{I_LB,  32'h0000_0050, 32'h0,         32'h0000_007F, 16'h0000, 1'b0, 5'd11, 32'h0000_007F, 2};
        vecs[9] = '{I_LHU, 32'h0000_0010, 32'h0,         32'h0000_8001, 16'h0001, 1'b1, 5'd12, 32'h0000_8001, 4};

        rst_in      = 1'b1;
        instIdx_in  = I_NOP;
        memAddr_in  = 32'h0;
        valStore_in = 32'h0;
        rdE_in      = 1'b1;
        rdIdx_in    = 5'd9;
        rdData_in   = 32'h5A5A_5A5A;
        memGrant_in = 1'b0;
        memData_in  = 8'h0;
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        check_reset_outputs("reset");
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;

        check_passthru(32'h0000_0055, 1'b1, 5'd7);

        for (int i = 0; i < 10; i++) begin
            run_txn(vecs[i].op, vecs[i].addr, vecs[i].sval, vecs[i].rbytes, vecs[i].gmask,
                    vecs[i].rde, vecs[i].ridx, vecs[i].exp_res, vecs[i].exp_stall);
        end

        for (int i = 0; i < 30; i++) begin
            int          sel   = $urandom_range(0, 8);
            logic [5:0]  op;
            logic [31:0] addr  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3)) : $urandom;
            logic [31:0] sval  = $urandom;
            logic [31:0] rb    = $urandom;
            logic [15:0] gm    = 16'($urandom & $urandom);
            logic        rde   = 1'($urandom);
            logic [4:0]  ridx  = 5'($urandom);
            case (sel)
                0: op = I_LB;  1: op = I_LH;  2: op = I_LW;  3: op = I_LBU;
                4: op = I_LHU; 5: op = I_SB;  6: op = I_SH;  7: op = I_SW;
                default: op = I_ADD;
            endcase
            if (op == I_ADD) begin
                check_passthru($urandom, rde, ridx);
            end else begin
                run_txn(op, addr, sval, rb, gm, rde, ridx, model_load(op, rb), model_stall(op, gm));
            end
        end

        // Store across the address wrap, aborted by reset after its second byte.
        instIdx_in  = I_SW;
        memAddr_in  = 32'hFFFF_FFFE;
        valStore_in = 32'hCAFE_F00D;
        rdE_in      = 1'b0;
        rdIdx_in    = 5'd0;
        memGrant_in = 1'b1;
        @(negedge clk_in);
        chk("abort_b0_addr", memAddr_out, 32'hFFFF_FFFE);
        chk("abort_b0_wr", 32'(memWr_out & memReq_out), 32'd1);
        chk("abort_b0_data", 32'(memData_out), 32'h0D);
        @(posedge clk_in);
        #1;
        @(negedge clk_in);
        chk("abort_b1_addr", memAddr_out, 32'hFFFF_FFFF);
        chk("abort_b1_data", 32'(memData_out), 32'hF0);
        @(posedge clk_in);
        #1;
        rst_in = 1'b1;
        @(negedge clk_in);
        chk("abort_no_wr", 32'(memWr_out), 32'd0);
        chk("abort_no_req", 32'(memReq_out), 32'd0);
        @(posedge clk_in);
        #1;
        instIdx_in = I_NOP;
        rdE_in     = 1'b1;
        rdIdx_in   = 5'd9;
        rdData_in  = 32'h5A5A_5A5A;
        @(negedge clk_in);
        check_reset_outputs("abort");
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;

        run_txn(I_LW, 32'h0000_4000, 32'h0, 32'h8765_4321, 16'h0000, 1'b1, 5'd13, 32'h8765_4321, 5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
